pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/loaduse_detect.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encodings and limits for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2,
        ERR     = 2'd3
    } ctrl_state_e;

    localparam int WAIT_MAX_DEFAULT = 255;

endpackage

// File: rtl/loaduse_detect.sv
// rtl/loaduse_detect.sv - flags an ID-stage source that depends on a load still in EX
module loaduse_detect (
    input  logic       mem2reg,
    input  logic       rf_wen,
    input  logic [3:0] waddr,
    input  logic [3:0] rs1,
    input  logic [3:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    output logic       loaduse
);

    logic hit_rs1;
    logic hit_rs2;

    assign hit_rs1 = use_rs1 & (rs1 == waddr);
    assign hit_rs2 = use_rs2 & (rs2 == waddr);

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign loaduse = mem2reg & rf_wen & (waddr != 4'd0) & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall, flush and bubble control for a five-stage pipeline
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ifid_rs1,
    input  logic [3:0]  ifid_rs2,
    input  logic        ifid_use_rs1,
    input  logic        ifid_use_rs2,
    input  logic        idex_mem2reg,
    input  logic        idex_rf_wen,
    input  logic [3:0]  idex_rf_waddr,
    input  logic        br_taken_ex,
    input  logic        jal_ex,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    input  logic        halt_req,
    input  logic        resume,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        stall_idex,
    output logic        stall_exmem,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        bubble_memwb,
    output logic        nop_lw,
    output logic [1:0]  state,
    output logic        err,
    output logic [15:0] stall_cnt
);

    localparam int WCW = $clog2(WAIT_MAX + 1);

    ctrl_state_e    state_q;
    logic [WCW-1:0] wait_cnt;
    logic           loaduse;
    logic           mem_wait;
    logic           hold;
    logic           xfer_flush;
    logic           lu_bubble;

    loaduse_detect u_loaduse (
        .mem2reg (idex_mem2reg),
        .rf_wen  (idex_rf_wen),
        .waddr   (idex_rf_waddr),
        .rs1     (ifid_rs1),
        .rs2     (ifid_rs2),
        .use_rs1 (ifid_use_rs1),
        .use_rs2 (ifid_use_rs2),
        .loaduse (loaduse)
    );

    assign mem_wait = dmem_req & ~dmem_ack;

    // Outputs follow the current state with no register delay; reset masks them all
    always_comb begin
        hold       = 1'b0;
        xfer_flush = 1'b0;
        lu_bubble  = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (mem_wait) begin
                        hold = 1'b1;
                    end else if (!halt_req) begin
                        if (br_taken_ex | jal_ex) begin
                            xfer_flush = 1'b1;
                        end else if (loaduse) begin
                            lu_bubble = 1'b1;
                        end
                    end
                end
                MEMWAIT: hold = ~dmem_ack;
                default: hold = 1'b1;
            endcase
        end
    end

    assign stall_pc     = hold | lu_bubble;
    assign stall_ifid   = hold | lu_bubble;
    assign stall_idex   = hold;
    assign stall_exmem  = hold;
    assign bubble_memwb = hold;
    assign flush_ifid   = xfer_flush;
    assign flush_idex   = xfer_flush | lu_bubble;
    assign nop_lw       = lu_bubble;
    assign state        = state_q;
    assign err          = (state_q == ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= 16'd0;
        end else begin
            if (stall_pc && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            case (state_q)
                RUN: begin
                    if (mem_wait) begin
                        state_q  <= MEMWAIT;
                        wait_cnt <= WCW'(1);
                    end else if (halt_req) begin
                        state_q <= HALT;
                    end
                end
                MEMWAIT: begin
                    // An ack arriving on the last allowed cycle still completes normally
                    if (dmem_ack) begin
                        state_q  <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt >= WCW'(WAIT_MAX)) begin
                        state_q <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HALT: begin
                    if (resume) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized checks of pipe_hazard_ctrl against a reference model
module tb_pipe_hazard_ctrl;

    localparam int WMAX = 4;
    localparam logic [7:0] HOLD_ALL = 8'b1111_0010;
    localparam logic [7:0] LU_OUT   = 8'b1100_0101;
    localparam logic [7:0] XFER_OUT = 8'b0000_1100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ifid_rs1, ifid_rs2, idex_rf_waddr;
    logic        ifid_use_rs1, ifid_use_rs2, idex_mem2reg, idex_rf_wen;
    logic        br_taken_ex, jal_ex, dmem_req, dmem_ack, halt_req, resume;
    logic        stall_pc, stall_ifid, stall_idex, stall_exmem;
    logic        flush_ifid, flush_idex, bubble_memwb, nop_lw, err;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [7:0]  obs;

    int errors = 0;
    int checks = 0;
    int m_mode = 0;
    int m_wait = 0;
    int m_stalls = 0;

    pipe_hazard_ctrl #(.WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst(rst),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .idex_mem2reg(idex_mem2reg), .idex_rf_wen(idex_rf_wen), .idex_rf_waddr(idex_rf_waddr),
        .br_taken_ex(br_taken_ex), .jal_ex(jal_ex),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .halt_req(halt_req), .resume(resume),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex), .stall_exmem(stall_exmem),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .bubble_memwb(bubble_memwb),
        .nop_lw(nop_lw), .state(state), .err(err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, bubble_memwb, nop_lw};

    // Expected output vector: reset masks, then state-specific rules in priority order
    function automatic logic [7:0] model_eval();
        bit lu;
        lu = idex_mem2reg && idex_rf_wen && (idex_rf_waddr != 0) &&
             ((ifid_use_rs1 && ifid_rs1 == idex_rf_waddr) || (ifid_use_rs2 && ifid_rs2 == idex_rf_waddr));
        if (rst) return 8'h00;
        if (m_mode == 0) begin
            if (dmem_req && !dmem_ack) return HOLD_ALL;
            if (halt_req) return 8'h00;
            if (br_taken_ex || jal_ex) return XFER_OUT;
            if (lu) return LU_OUT;
            return 8'h00;
        end
        if (m_mode == 1) return dmem_ack ? 8'h00 : HOLD_ALL;
        return HOLD_ALL;
    endfunction

    task automatic model_step();
        logic [7:0] e;
        e = model_eval();
        if (rst) begin
            m_mode = 0; m_wait = 0; m_stalls = 0;
        end else begin
            if (e[7] && m_stalls < 65535) m_stalls++;
            case (m_mode)
                0: if (dmem_req && !dmem_ack) begin m_mode = 1; m_wait = 1; end
                   else if (halt_req) m_mode = 2;
                1: if (dmem_ack) begin m_mode = 0; m_wait = 0; end
                   else if (m_wait >= WMAX) m_mode = 3;
                   else m_wait++;
                2: if (resume) m_mode = 0;
                default: m_mode = 3;
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifid_rs1 = 0; ifid_rs2 = 0; ifid_use_rs1 = 0; ifid_use_rs2 = 0;
        idex_mem2reg = 0; idex_rf_wen = 0; idex_rf_waddr = 0;
        br_taken_ex = 0; jal_ex = 0; dmem_req = 0; dmem_ack = 0; halt_req = 0; resume = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        idex_mem2reg = 1; idex_rf_wen = 1; idex_rf_waddr = 4'd7;
        ifid_rs1 = 4'd7; ifid_use_rs1 = 1; dmem_req = 1;
        @(negedge clk);
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL reset_outputs got=%b want=%b", obs, 8'h00); end
        checks++;
        if (state !== 2'd0 || err !== 1'b0 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_state got state=%0d err=%b cnt=%0d want 0/0/0", state, err, stall_cnt);
        end
        tick();
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_loaduse();
        do_reset();
        idex_mem2reg = 1; idex_rf_wen = 1; idex_rf_waddr = 4'd3;
        ifid_rs1 = 4'd3; ifid_use_rs1 = 1; ifid_rs2 = 4'd5; ifid_use_rs2 = 1;
        @(negedge clk);
        checks++;
        if (obs !== LU_OUT) begin errors++; $display("FAIL loaduse_stall got=%b want=%b", obs, LU_OUT); end
        tick();
        idex_mem2reg = 0; idex_rf_wen = 0;
        @(negedge clk);
        checks++;
        if (obs !== 8'h00 || stall_cnt !== 16'd1) begin
            errors++; $display("FAIL loaduse_issue got=%b cnt=%0d want=%b cnt=1", obs, stall_cnt, 8'h00);
        end
        tick();
    endtask

    task automatic test_r0_and_unused();
        do_reset();
        idex_mem2reg = 1; idex_rf_wen = 1; idex_rf_waddr = 4'd0;
        ifid_rs1 = 4'd0; ifid_use_rs1 = 1; ifid_rs2 = 4'd0; ifid_use_rs2 = 1;
        @(negedge clk);
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL r0_no_stall got=%b want=%b", obs, 8'h00); end
        tick();
        idex_rf_waddr = 4'd9; ifid_rs1 = 4'd1; ifid_rs2 = 4'd9; ifid_use_rs2 = 0;
        @(negedge clk);
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL unused_rs2 got=%b want=%b", obs, 8'h00); end
        tick();
    endtask

    task automatic test_branch_priority();
        do_reset();
        idex_mem2reg = 1; idex_rf_wen = 1; idex_rf_waddr = 4'd6;
        ifid_rs2 = 4'd6; ifid_use_rs2 = 1; br_taken_ex = 1;
        @(negedge clk);
        checks++;
        if (obs !== XFER_OUT) begin errors++; $display("FAIL branch_over_loaduse got=%b want=%b", obs, XFER_OUT); end
        tick();
        br_taken_ex = 0; jal_ex = 1;
        @(negedge clk);
        checks++;
        if (obs !== XFER_OUT) begin errors++; $display("FAIL jal_flush got=%b want=%b", obs, XFER_OUT); end
        tick();
    endtask

    task automatic test_memwait();
        do_reset();
        dmem_req = 1;
        @(negedge clk);
        checks++;
        if (obs !== HOLD_ALL || state !== 2'd0) begin
            errors++; $display("FAIL mem_request got=%b st=%0d want=%b st=0", obs, state, HOLD_ALL);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            @(negedge clk);
            checks++;
            if (state !== 2'd1 || obs !== (i == 3 ? 8'h00 : HOLD_ALL)) begin
                errors++; $display("FAIL memwait_%0d got st=%0d obs=%b want st=1", i, state, obs);
            end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || stall_cnt !== 16'd4 || obs !== 8'h00) begin
            errors++; $display("FAIL mem_done got st=%0d cnt=%0d obs=%b want st=0 cnt=4", state, stall_cnt, obs);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        dmem_req = 1;
        tick();
        for (int i = 0; i < WMAX; i++) begin
            @(negedge clk);
            checks++;
            if (state !== 2'd1 || obs !== HOLD_ALL) begin
                errors++; $display("FAIL timeout_wait_%0d got st=%0d obs=%b want st=1", i, state, obs);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            resume = 1; halt_req = i[0]; dmem_ack = (i == 2);
            @(negedge clk);
            checks++;
            if (state !== 2'd3 || err !== 1'b1 || obs !== HOLD_ALL) begin
                errors++; $display("FAIL err_sticky_%0d got st=%0d err=%b obs=%b want st=3 err=1", i, state, err, obs);
            end
            tick();
        end
        rst = 1;
        #1;
        checks++;
        if (state !== 2'd0 || err !== 1'b0 || obs !== 8'h00) begin
            errors++; $display("FAIL err_reset got st=%0d err=%b obs=%b want 0/0/0", state, err, obs);
        end
        tick();
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_halt();
        do_reset();
        halt_req = 1; br_taken_ex = 1;
        @(negedge clk);
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL halt_entry got=%b want=%b", obs, 8'h00); end
        tick();
        br_taken_ex = 0;
        for (int i = 1; i <= 5; i++) begin
            resume = (i == 5);
            @(negedge clk);
            checks++;
            if (state !== 2'd2 || obs !== HOLD_ALL) begin
                errors++; $display("FAIL halt_cycle_%0d got st=%0d obs=%b want st=2", i, state, obs);
            end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || obs !== 8'h00 || stall_cnt !== 16'd5) begin
            errors++; $display("FAIL halt_resume got st=%0d obs=%b cnt=%0d want st=0 cnt=5", state, obs, stall_cnt);
        end
        halt_req = 1;
        tick();
        halt_req = 0;
        tick();
        rst = 1;
        #1;
        checks++;
        if (state !== 2'd0 || obs !== 8'h00 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL halt_reset got st=%0d obs=%b cnt=%0d want 0", state, obs, stall_cnt);
        end
        tick();
        rst = 0;
    endtask

    task automatic test_random();
        logic [7:0] e;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            ifid_rs1 = 4'($urandom_range(0, 3));
            ifid_rs2 = 4'($urandom_range(0, 3));
            ifid_use_rs1 = ($urandom_range(0, 3) != 0);
            ifid_use_rs2 = ($urandom_range(0, 1) != 0);
            idex_mem2reg = ($urandom_range(0, 1) != 0);
            idex_rf_wen = ($urandom_range(0, 3) != 0);
            idex_rf_waddr = 4'($urandom_range(0, 3));
            br_taken_ex = ($urandom_range(0, 5) == 0);
            jal_ex = ($urandom_range(0, 7) == 0);
            dmem_req = ($urandom_range(0, 5) == 0);
            dmem_ack = ($urandom_range(0, 2) == 0);
            halt_req = ($urandom_range(0, 9) == 0);
            resume = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            e = model_eval();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL rand_outputs n=%0d got=%b want=%b", n, obs, e); end
            checks++;
            if (state !== (rst ? 2'd0 : 2'(m_mode)) || err !== (!rst && m_mode == 3)) begin
                errors++; $display("FAIL rand_state n=%0d got st=%0d err=%b want st=%0d", n, state, err, rst ? 0 : m_mode);
            end
            checks++;
            if (stall_cnt !== (rst ? 16'd0 : 16'(m_stalls))) begin
                errors++; $display("FAIL rand_stall_cnt n=%0d got=%0d want=%0d", n, stall_cnt, rst ? 0 : m_stalls);
            end
            tick();
        end
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_loaduse();
        test_r0_and_unused();
        test_branch_priority();
        test_memwait();
        test_timeout();
        test_halt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
